// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one SRAM-like bus between the instruction fetch (IF) port and the
//   data (MEM) port. Only one bus transaction is in flight at a time. The data
//   side wins when both sides request in the same cycle.
//
//   Handshake semantics:
//     Upstream request ports (inst_req_i / data_req_i) are level requests. They
//     stay high until the matching x_valid_o pulse. x_valid_o is a
//     single-cycle completion strobe, and x_rdata_o is valid in that cycle.
//     On the bus, bus_req_o is the valid and bus_addr_ok_i is the ready. The
//     request fields stay frozen until the cycle where both are 1. After that,
//     bus_data_ok_i is a single-cycle response strobe that carries
//     bus_rdata_i. It is honoured only while a response is awaited.
//
//   Ports:
//     clk, rst_n                  clock, asynchronous active-low reset
//     flush_i                     pipeline flush; cancels instruction traffic
//     inst_req_i/inst_addr_i      fetch request and address
//     inst_rdata_o/inst_valid_o   fetched word and completion pulse
//     stallreq_if_o               IF-side stall request (combinational)
//     data_req_i/_we_i/_wstrb_i/_addr_i/_wdata_i   MEM-side request
//     data_rdata_o/data_valid_o   load data and completion pulse
//     stallreq_mem_o              MEM-side stall request (combinational)
//     bus_req_o/_we_o/_wstrb_o/_addr_o/_wdata_o    shared bus request channel
//     bus_addr_ok_i               bus request accepted
//     bus_data_ok_i/bus_rdata_i   bus response strobe and read data
//     dbg_state_o                 current FSM state (encoding of state_t)
module mem_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush_i,
  input  logic                inst_req_i,
  input  logic [ADDR_W-1:0]   inst_addr_i,
  output logic [DATA_W-1:0]   inst_rdata_o,
  output logic                inst_valid_o,
  output logic                stallreq_if_o,
  input  logic                data_req_i,
  input  logic                data_we_i,
  input  logic [DATA_W/8-1:0] data_wstrb_i,
  input  logic [ADDR_W-1:0]   data_addr_i,
  input  logic [DATA_W-1:0]   data_wdata_i,
  output logic [DATA_W-1:0]   data_rdata_o,
  output logic                data_valid_o,
  output logic                stallreq_mem_o,
  output logic                bus_req_o,
  output logic                bus_we_o,
  output logic [DATA_W/8-1:0] bus_wstrb_o,
  output logic [ADDR_W-1:0]   bus_addr_o,
  output logic [DATA_W-1:0]   bus_wdata_o,
  input  logic                bus_addr_ok_i,
  input  logic                bus_data_ok_i,
  input  logic [DATA_W-1:0]   bus_rdata_i,
  output logic [2:0]          dbg_state_o
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDR_D = 3'd1,
    S_ADDR_I = 3'd2,
    S_WAIT_D = 3'd3,
    S_WAIT_I = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_next;

  // Request fields latched at grant. The bus is driven only from these.
  logic                r_sel_d;
  logic                r_we;
  logic [STRB_W-1:0]   r_wstrb;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;

  // Sticky cancel for an instruction transaction hit by a flush.
  logic                r_cancel;
  logic [DATA_W-1:0]   r_inst_rdata;
  logic [DATA_W-1:0]   r_data_rdata;

  logic                w_grant_d;
  logic                w_grant_i;
  logic                w_flush_inst;
  logic                w_drop_i;
  logic                w_cap_i;
  logic                w_cap_d;
  logic                w_inst_valid;
  logic                w_data_valid;

  // A response that arrives while the flush is still high is dropped, the
  // same as one that arrives after an earlier flush.
  assign w_drop_i     = r_cancel | flush_i;
  assign w_grant_d    = (r_state == S_IDLE) && (w_next == S_ADDR_D);
  assign w_grant_i    = (r_state == S_IDLE) && (w_next == S_ADDR_I);
  assign w_flush_inst = flush_i && ((r_state == S_ADDR_I) || (r_state == S_WAIT_I));
  assign w_cap_d      = (r_state == S_WAIT_D) && bus_data_ok_i;
  assign w_cap_i      = (r_state == S_WAIT_I) && bus_data_ok_i && !w_drop_i;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        // A flush holds off every grant in its cycle. The pipeline is
        // redirecting, so the fetch address presented now is stale.
        if (!flush_i) begin
          if (data_req_i) begin
            w_next = S_ADDR_D;
          end else if (inst_req_i) begin
            w_next = S_ADDR_I;
          end
        end
      end
      S_ADDR_D: if (bus_addr_ok_i) w_next = S_WAIT_D;
      S_ADDR_I: if (bus_addr_ok_i) w_next = S_WAIT_I;
      S_WAIT_D: if (bus_data_ok_i) w_next = S_DONE;
      S_WAIT_I: begin
        if (bus_data_ok_i) begin
          w_next = w_drop_i ? S_IDLE : S_DONE;
        end
      end
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus_req_o    = 1'b0;
    w_inst_valid = 1'b0;
    w_data_valid = 1'b0;
    case (r_state)
      S_ADDR_D, S_ADDR_I: bus_req_o = 1'b1;
      S_DONE: begin
        w_inst_valid = ~r_sel_d;
        w_data_valid = r_sel_d;
      end
      default: ;
    endcase
  end

  assign inst_valid_o   = w_inst_valid;
  assign data_valid_o   = w_data_valid;
  // The IF side also stalls while MEM is requesting, because the data side
  // owns the next bus slot.
  assign stallreq_mem_o = data_req_i & ~w_data_valid;
  assign stallreq_if_o  = (inst_req_i & ~w_inst_valid) | data_req_i;

  assign bus_we_o     = r_we;
  assign bus_wstrb_o  = r_wstrb;
  assign bus_addr_o   = r_addr;
  assign bus_wdata_o  = r_wdata;
  assign inst_rdata_o = r_inst_rdata;
  assign data_rdata_o = r_data_rdata;
  assign dbg_state_o  = r_state;

  // Latched request fields, cancel flag and read-data holding registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel_d      <= 1'b0;
      r_we         <= 1'b0;
      r_wstrb      <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_cancel     <= 1'b0;
      r_inst_rdata <= '0;
      r_data_rdata <= '0;
    end else begin
      if (w_grant_d) begin
        r_sel_d <= 1'b1;
        r_we    <= data_we_i;
        r_wstrb <= data_wstrb_i;
        r_addr  <= data_addr_i;
        r_wdata <= data_wdata_i;
      end else if (w_grant_i) begin
        r_sel_d <= 1'b0;
        r_we    <= 1'b0;
        r_wstrb <= '0;
        r_addr  <= inst_addr_i;
        r_wdata <= '0;
      end

      if (w_next == S_IDLE) begin
        r_cancel <= 1'b0;
      end else if (w_flush_inst) begin
        r_cancel <= 1'b1;
      end

      if (w_cap_d) r_data_rdata <= bus_rdata_i;
      if (w_cap_i) r_inst_rdata <= bus_rdata_i;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter. The bench drives inputs 1 time unit after the
// rising edge and samples outputs on the falling edge. Completion responses
// are queued as {side, rdata} (side 1 = data) when a request is issued, and
// are popped when a valid pulse appears.
module tb_mem_bus_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_WAIT_D = 3'd3;
  localparam logic [2:0] ST_WAIT_I = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  logic              clk;
  logic              rst_n;
  logic              flush_i;
  logic              inst_req_i;
  logic [ADDR_W-1:0] inst_addr_i;
  logic [DATA_W-1:0] inst_rdata_o;
  logic              inst_valid_o;
  logic              stallreq_if_o;
  logic              data_req_i;
  logic              data_we_i;
  logic [STRB_W-1:0] data_wstrb_i;
  logic [ADDR_W-1:0] data_addr_i;
  logic [DATA_W-1:0] data_wdata_i;
  logic [DATA_W-1:0] data_rdata_o;
  logic              data_valid_o;
  logic              stallreq_mem_o;
  logic              bus_req_o;
  logic              bus_we_o;
  logic [STRB_W-1:0] bus_wstrb_o;
  logic [ADDR_W-1:0] bus_addr_o;
  logic [DATA_W-1:0] bus_wdata_o;
  logic              bus_addr_ok_i;
  logic              bus_data_ok_i;
  logic [DATA_W-1:0] bus_rdata_i;
  logic [2:0]        dbg_state_o;

  logic [DATA_W:0]   exp_q[$];
  logic [DATA_W:0]   exp_v;
  logic [DATA_W:0]   got_v;
  logic [DATA_W-1:0] inst_model;
  int                n_vec;
  int                n_err;

  mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .inst_req_i(inst_req_i), .inst_addr_i(inst_addr_i),
    .inst_rdata_o(inst_rdata_o), .inst_valid_o(inst_valid_o),
    .stallreq_if_o(stallreq_if_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_wstrb_i(data_wstrb_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
    .data_rdata_o(data_rdata_o), .data_valid_o(data_valid_o),
    .stallreq_mem_o(stallreq_mem_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_wstrb_o(bus_wstrb_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
    .bus_addr_ok_i(bus_addr_ok_i), .bus_data_ok_i(bus_data_ok_i),
    .bus_rdata_i(bus_rdata_i), .dbg_state_o(dbg_state_o)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, need run completion");
    $fatal(1, "watchdog expired");
  end

  // Bus slave driver: wait for bus_req_o, hold off addr_ok for a_dly cycles,
  // then accept. Returns 1 time unit after the edge that enters WAIT.
  task automatic serve_addr(input int a_dly);
    int t;
    t = 0;
    @(negedge clk);
    while (bus_req_o !== 1'b1 && t < 32) begin
      @(negedge clk);
      t++;
    end
    n_vec++;
    if (bus_req_o !== 1'b1) begin
      n_err++;
      $display("FAIL bus_req_timeout: bus_req_o=%b after %0d cycles, need 1", bus_req_o, t);
    end
    repeat (a_dly) @(negedge clk);
    bus_addr_ok_i = 1'b1;
    @(posedge clk); #1;
    bus_addr_ok_i = 1'b0;
  endtask

  // Bus slave driver: after d_dly further cycles, return rdata for one cycle.
  task automatic serve_data(input int d_dly, input logic [DATA_W-1:0] rdata);
    repeat (d_dly) @(negedge clk);
    bus_data_ok_i = 1'b1;
    bus_rdata_i   = rdata;
    @(posedge clk); #1;
    bus_data_ok_i = 1'b0;
    bus_rdata_i   = $urandom;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush_i = 1'b0;
    inst_req_i = 1'b0; inst_addr_i = '0;
    data_req_i = 1'b0; data_we_i = 1'b0; data_wstrb_i = '0;
    data_addr_i = '0; data_wdata_i = '0;
    bus_addr_ok_i = 1'b0; bus_data_ok_i = 1'b0; bus_rdata_i = '0;
    inst_model = '0;
    @(negedge clk);
    n_vec++;
    if ({bus_req_o, bus_we_o, bus_wstrb_o, bus_addr_o, bus_wdata_o, inst_valid_o, data_valid_o,
         inst_rdata_o, data_rdata_o, stallreq_if_o, stallreq_mem_o, dbg_state_o} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: bus_req=%b addr=%h state=%0d rdata i/d=%h/%h, need all 0",
               bus_req_o, bus_addr_o, dbg_state_o, inst_rdata_o, data_rdata_o);
    end
    // The first grant lands on the first rising edge after release.
    inst_req_i  = 1'b1;
    inst_addr_i = 32'h1C000100;
    exp_q.push_back({1'b0, 32'hA5A5_0001});
    #1;
    n_vec++;
    if (stallreq_if_o !== 1'b1 || bus_req_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_stall_if: stall_if=%b bus_req=%b, need 1/0", stallreq_if_o, bus_req_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (bus_req_o !== 1'b1 || bus_addr_o !== 32'h1C000100) begin
      n_err++;
      $display("FAIL reset_first_grant: bus_req=%b addr=%h, need 1/1c000100", bus_req_o, bus_addr_o);
    end
    serve_addr(0);
    serve_data(0, 32'hA5A5_0001);
    @(negedge clk);
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++; $display("FAIL reset_resp: no expected entry, valid i/d=%b/%b", inst_valid_o, data_valid_o);
    end else begin
      exp_v = exp_q.pop_front();
      got_v = {data_valid_o, (data_valid_o ? data_rdata_o : inst_rdata_o)};
      if ((inst_valid_o ^ data_valid_o) !== 1'b1 || got_v !== exp_v) begin
        n_err++;
        $display("FAIL reset_resp: valid i/d=%b/%b got %h, need one valid with %h", inst_valid_o, data_valid_o, got_v, exp_v);
      end
    end
    inst_model = 32'hA5A5_0001;
    @(posedge clk); #1;
    inst_req_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] rd2;
    rd2 = $urandom;
    inst_req_i  = 1'b1;                              // cycle 0
    inst_addr_i = 32'h1C000000;
    exp_q.push_back({1'b0, 32'h02800421});
    @(negedge clk);
    n_vec++;
    if (bus_req_o !== 1'b0 || stallreq_if_o !== 1'b1) begin
      n_err++; $display("FAIL fetch_c0: bus_req=%b stall_if=%b, need 0/1", bus_req_o, stallreq_if_o);
    end
    @(posedge clk); #1;                              // cycle 1
    bus_addr_ok_i = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({bus_req_o, bus_addr_o, bus_we_o, bus_wstrb_o, stallreq_if_o} !== {1'b1, 32'h1C000000, 1'b0, 4'h0, 1'b1}) begin
      n_err++;
      $display("FAIL fetch_c1: req=%b addr=%h we=%b strb=%h stall_if=%b, need 1/1c000000/0/0/1",
               bus_req_o, bus_addr_o, bus_we_o, bus_wstrb_o, stallreq_if_o);
    end
    @(posedge clk); #1;                              // cycle 2
    bus_addr_ok_i = 1'b0;
    bus_data_ok_i = 1'b1;
    bus_rdata_i   = 32'h02800421;
    @(negedge clk);
    n_vec++;
    if (bus_req_o !== 1'b0 || inst_valid_o !== 1'b0 || stallreq_if_o !== 1'b1) begin
      n_err++; $display("FAIL fetch_c2: req=%b valid=%b stall_if=%b, need 0/0/1", bus_req_o, inst_valid_o, stallreq_if_o);
    end
    @(posedge clk); #1;                              // cycle 3 (inst_req still high)
    bus_data_ok_i = 1'b0;
    bus_rdata_i   = $urandom;
    @(negedge clk);
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++; $display("FAIL fetch_resp: no expected entry, valid i/d=%b/%b", inst_valid_o, data_valid_o);
    end else begin
      exp_v = exp_q.pop_front();
      got_v = {data_valid_o, (data_valid_o ? data_rdata_o : inst_rdata_o)};
      if ((inst_valid_o ^ data_valid_o) !== 1'b1 || got_v !== exp_v) begin
        n_err++;
        $display("FAIL fetch_resp: valid i/d=%b/%b got %h, need one valid with %h", inst_valid_o, data_valid_o, got_v, exp_v);
      end
    end
    inst_model = 32'h02800421;
    n_vec++;
    if (bus_req_o !== 1'b0 || stallreq_if_o !== 1'b0 || dbg_state_o !== ST_DONE) begin
      n_err++; $display("FAIL fetch_c3: req=%b stall_if=%b state=%0d, need 0/0/5", bus_req_o, stallreq_if_o, dbg_state_o);
    end
    @(posedge clk); #1;                              // cycle 4
    inst_addr_i = 32'h1C000004;
    exp_q.push_back({1'b0, rd2});
    @(negedge clk);
    n_vec++;
    if (bus_req_o !== 1'b0 || inst_valid_o !== 1'b0 || dbg_state_o !== ST_IDLE) begin
      n_err++; $display("FAIL b2b_c4: req=%b valid=%b state=%0d, need 0/0/0", bus_req_o, inst_valid_o, dbg_state_o);
    end
    @(posedge clk); #1;                              // cycle 5
    @(negedge clk);
    n_vec++;
    if (bus_req_o !== 1'b1 || bus_addr_o !== 32'h1C000004) begin
      n_err++; $display("FAIL b2b_c5: req=%b addr=%h, need 1/1c000004", bus_req_o, bus_addr_o);
    end
    serve_addr(0);
    serve_data(0, rd2);
    @(negedge clk);
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++; $display("FAIL b2b_resp: no expected entry, valid i/d=%b/%b", inst_valid_o, data_valid_o);
    end else begin
      exp_v = exp_q.pop_front();
      got_v = {data_valid_o, (data_valid_o ? data_rdata_o : inst_rdata_o)};
      if ((inst_valid_o ^ data_valid_o) !== 1'b1 || got_v !== exp_v) begin
        n_err++;
        $display("FAIL b2b_resp: valid i/d=%b/%b got %h, need one valid with %h", inst_valid_o, data_valid_o, got_v, exp_v);
      end
    end
    inst_model = rd2;
    @(posedge clk); #1;
    inst_req_i = 1'b0;
  endtask

  task automatic test_contention();
    logic [DATA_W-1:0] rd_d, rd_i;
    rd_d = $urandom;
    rd_i = $urandom;
    inst_req_i = 1'b1; inst_addr_i = 32'h1C000040;
    data_req_i = 1'b1; data_we_i = 1'b1; data_wstrb_i = 4'hF;
    data_addr_i = 32'h1C008000; data_wdata_i = 32'hDEADBEEF;
    exp_q.push_back({1'b1, rd_d});
    exp_q.push_back({1'b0, rd_i});
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++;
    if ({bus_req_o, bus_we_o, bus_wstrb_o, bus_addr_o, bus_wdata_o, stallreq_if_o, stallreq_mem_o} !==
        {1'b1, 1'b1, 4'hF, 32'h1C008000, 32'hDEADBEEF, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL cont_data_grant: req=%b we=%b strb=%h addr=%h wdata=%h stall if/mem=%b/%b, need 1/1/f/1c008000/deadbeef/1/1",
               bus_req_o, bus_we_o, bus_wstrb_o, bus_addr_o, bus_wdata_o, stallreq_if_o, stallreq_mem_o);
    end
    serve_addr(0);
    serve_data(0, rd_d);
    @(negedge clk);
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++; $display("FAIL cont_resp_d: no expected entry, valid i/d=%b/%b", inst_valid_o, data_valid_o);
    end else begin
      exp_v = exp_q.pop_front();
      got_v = {data_valid_o, (data_valid_o ? data_rdata_o : inst_rdata_o)};
      if ((inst_valid_o ^ data_valid_o) !== 1'b1 || got_v !== exp_v) begin
        n_err++;
        $display("FAIL cont_resp_d: valid i/d=%b/%b got %h, need one valid with %h", inst_valid_o, data_valid_o, got_v, exp_v);
      end
    end
    n_vec++;
    if (stallreq_mem_o !== 1'b0 || bus_req_o !== 1'b0) begin
      n_err++; $display("FAIL cont_done_d: stall_mem=%b req=%b, need 0/0", stallreq_mem_o, bus_req_o);
    end
    @(posedge clk); #1;
    data_req_i = 1'b0;
    @(negedge clk);
    n_vec++;
    if (stallreq_if_o !== 1'b1 || stallreq_mem_o !== 1'b0 || bus_req_o !== 1'b0) begin
      n_err++; $display("FAIL cont_idle: stall if/mem=%b/%b req=%b, need 1/0/0", stallreq_if_o, stallreq_mem_o, bus_req_o);
    end
    serve_addr(0);
    @(negedge clk);
    n_vec++;
    if ({bus_we_o, bus_wstrb_o, bus_addr_o} !== {1'b0, 4'h0, 32'h1C000040}) begin
      n_err++; $display("FAIL cont_inst_fields: we=%b strb=%h addr=%h, need 0/0/1c000040", bus_we_o, bus_wstrb_o, bus_addr_o);
    end
    serve_data(1, rd_i);
    @(negedge clk);
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++; $display("FAIL cont_resp_i: no expected entry, valid i/d=%b/%b", inst_valid_o, data_valid_o);
    end else begin
      exp_v = exp_q.pop_front();
      got_v = {data_valid_o, (data_valid_o ? data_rdata_o : inst_rdata_o)};
      if ((inst_valid_o ^ data_valid_o) !== 1'b1 || got_v !== exp_v) begin
        n_err++;
        $display("FAIL cont_resp_i: valid i/d=%b/%b got %h, need one valid with %h", inst_valid_o, data_valid_o, got_v, exp_v);
      end
    end
    inst_model = rd_i;
    @(posedge clk); #1;
    inst_req_i = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] rd, wd;
    logic [ADDR_W-1:0] ad;
    rd = $urandom; wd = $urandom; ad = $urandom;
    data_req_i = 1'b1; data_we_i = 1'b1; data_wstrb_i = 4'b0110;
    data_addr_i = ad; data_wdata_i = wd;
    exp_q.push_back({1'b1, rd});
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      // A stray data_ok during the address phase must be ignored.
      bus_data_ok_i = (i < 4);
      bus_rdata_i   = $urandom;
      @(negedge clk);
      n_vec++;
      if ({bus_req_o, bus_we_o, bus_wstrb_o, bus_addr_o, bus_wdata_o} !== {1'b1, 1'b1, 4'b0110, ad, wd}) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: req=%b we=%b strb=%h addr=%h wdata=%h, need 1/1/6/%h/%h",
                 i, bus_req_o, bus_we_o, bus_wstrb_o, bus_addr_o, bus_wdata_o, ad, wd);
      end
      // The upstream request may change once the grant has latched it.
      data_addr_i  = $urandom;
      data_wdata_i = $urandom;
      if (i == 4) bus_addr_ok_i = 1'b1;
      @(posedge clk); #1;
      bus_data_ok_i = 1'b0;
    end
    bus_addr_ok_i = 1'b0;
    serve_data(3, rd);
    @(negedge clk);
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++; $display("FAIL bp_resp: no expected entry, valid i/d=%b/%b", inst_valid_o, data_valid_o);
    end else begin
      exp_v = exp_q.pop_front();
      got_v = {data_valid_o, (data_valid_o ? data_rdata_o : inst_rdata_o)};
      if ((inst_valid_o ^ data_valid_o) !== 1'b1 || got_v !== exp_v) begin
        n_err++;
        $display("FAIL bp_resp: valid i/d=%b/%b got %h, need one valid with %h", inst_valid_o, data_valid_o, got_v, exp_v);
      end
    end
    @(posedge clk); #1;
    data_req_i = 1'b0;
    @(negedge clk);
    n_vec++;
    if (data_valid_o !== 1'b0 || data_rdata_o !== rd) begin
      n_err++; $display("FAIL bp_single_pulse: valid=%b rdata=%h, need 0/%h", data_valid_o, data_rdata_o, rd);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    logic [DATA_W-1:0] rd;
    inst_req_i = 1'b1; inst_addr_i = 32'h1C000200; flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    @(negedge clk);
    n_vec++;
    if (bus_req_o !== 1'b0 || dbg_state_o !== ST_IDLE) begin
      n_err++; $display("FAIL flush_idle: req=%b state=%0d, need 0/0", bus_req_o, dbg_state_o);
    end
    serve_addr(0);
    flush_i = 1'b1; inst_req_i = 1'b0;
    @(negedge clk);
    n_vec++;
    if (dbg_state_o !== ST_WAIT_I) begin
      n_err++; $display("FAIL flush_wait_state: state=%0d, need 4", dbg_state_o);
    end
    @(posedge clk); #1;
    flush_i = 1'b0;
    serve_data(1, 32'h12345678);
    @(negedge clk);
    n_vec++;
    if (inst_valid_o !== 1'b0 || inst_rdata_o !== inst_model || dbg_state_o !== ST_IDLE) begin
      n_err++;
      $display("FAIL flush_cancel: valid=%b rdata=%h state=%0d, need 0/%h/0", inst_valid_o, inst_rdata_o, dbg_state_o, inst_model);
    end
    @(posedge clk); #1;
    // The flush arrives in the same cycle as data_ok.
    inst_req_i = 1'b1; inst_addr_i = 32'h1C000300;
    serve_addr(0);
    flush_i = 1'b1; inst_req_i = 1'b0;
    serve_data(0, 32'hCAFEF00D);
    flush_i = 1'b0;
    @(negedge clk);
    n_vec++;
    if (inst_valid_o !== 1'b0 || inst_rdata_o !== inst_model || dbg_state_o !== ST_IDLE) begin
      n_err++;
      $display("FAIL flush_coincident: valid=%b rdata=%h state=%0d, need 0/%h/0", inst_valid_o, inst_rdata_o, dbg_state_o, inst_model);
    end
    @(posedge clk); #1;
    rd = $urandom;
    inst_req_i = 1'b1; inst_addr_i = 32'h1C000400;
    exp_q.push_back({1'b0, rd});
    serve_addr(1);
    serve_data(2, rd);
    @(negedge clk);
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++; $display("FAIL flush_next_resp: no expected entry, valid i/d=%b/%b", inst_valid_o, data_valid_o);
    end else begin
      exp_v = exp_q.pop_front();
      got_v = {data_valid_o, (data_valid_o ? data_rdata_o : inst_rdata_o)};
      if ((inst_valid_o ^ data_valid_o) !== 1'b1 || got_v !== exp_v) begin
        n_err++;
        $display("FAIL flush_next_resp: valid i/d=%b/%b got %h, need one valid with %h", inst_valid_o, data_valid_o, got_v, exp_v);
      end
    end
    inst_model = rd;
    @(posedge clk); #1;
    inst_req_i = 1'b0;
  endtask

  task automatic test_random();
    logic              side;
    logic [DATA_W-1:0] rd;
    logic [ADDR_W-1:0] ad;
    int                a_dly, d_dly;
    for (int k = 0; k < 8; k++) begin
      side = 1'($urandom_range(0, 1));
      a_dly = $urandom_range(0, 3);
      d_dly = $urandom_range(0, 3);
      rd = $urandom; ad = $urandom;
      exp_q.push_back({side, rd});
      if (side) begin
        data_req_i = 1'b1; data_we_i = 1'($urandom_range(0, 1));
        data_wstrb_i = 4'($urandom_range(0, 15)); data_addr_i = ad; data_wdata_i = $urandom;
      end else begin
        inst_req_i = 1'b1; inst_addr_i = ad;
      end
      serve_addr(a_dly);
      @(negedge clk);
      n_vec++;
      if ({bus_addr_o, bus_we_o, bus_wstrb_o} !== (side ? {ad, data_we_i, data_wstrb_i} : {ad, 1'b0, 4'h0})) begin
        n_err++;
        $display("FAIL rand_fields[%0d]: side=%b addr=%h we=%b strb=%h, need addr %h", k, side, bus_addr_o, bus_we_o, bus_wstrb_o, ad);
      end
      serve_data(d_dly, rd);
      @(negedge clk);
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++; $display("FAIL rand_resp[%0d]: no expected entry, valid i/d=%b/%b", k, inst_valid_o, data_valid_o);
      end else begin
        exp_v = exp_q.pop_front();
        got_v = {data_valid_o, (data_valid_o ? data_rdata_o : inst_rdata_o)};
        if ((inst_valid_o ^ data_valid_o) !== 1'b1 || got_v !== exp_v) begin
          n_err++;
          $display("FAIL rand_resp[%0d]: valid i/d=%b/%b got %h, need one valid with %h", k, inst_valid_o, data_valid_o, got_v, exp_v);
        end
      end
      if (!side) inst_model = rd;
      @(posedge clk); #1;
      inst_req_i = 1'b0;
      data_req_i = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    data_req_i = 1'b1; data_we_i = 1'b0; data_wstrb_i = 4'hF;
    data_addr_i = 32'h1C00_9000; data_wdata_i = '0;
    serve_addr(0);
    @(negedge clk);
    n_vec++;
    if (dbg_state_o !== ST_WAIT_D) begin
      n_err++; $display("FAIL rst_mid_state: state=%0d, need 3", dbg_state_o);
    end
    #1;
    rst_n = 1'b0;
    data_req_i = 1'b0;
    #1;
    n_vec++;
    if ({bus_req_o, bus_we_o, bus_wstrb_o, bus_addr_o, bus_wdata_o, inst_valid_o, data_valid_o,
         inst_rdata_o, data_rdata_o, stallreq_if_o, stallreq_mem_o, dbg_state_o} !== '0) begin
      n_err++;
      $display("FAIL rst_mid_outputs: req=%b addr=%h strb=%h rdata i/d=%h/%h state=%0d, need all 0",
               bus_req_o, bus_addr_o, bus_wstrb_o, inst_rdata_o, data_rdata_o, dbg_state_o);
    end
    inst_model = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    bus_data_ok_i = 1'b1;
    bus_rdata_i   = 32'h5A5A_C3C3;
    @(posedge clk); #1;
    bus_data_ok_i = 1'b0;
    @(negedge clk);
    n_vec++;
    if (data_valid_o !== 1'b0 || data_rdata_o !== '0 || dbg_state_o !== ST_IDLE || bus_req_o !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_stray_ok: valid=%b rdata=%h state=%0d req=%b, need 0/0/0/0",
               data_valid_o, data_rdata_o, dbg_state_o, bus_req_o);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_back_to_back();
    test_contention();
    test_backpressure();
    test_flush();
    test_random();
    test_reset_mid();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL queue_drain: %0d responses never completed, need 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
